dmem_arbiter: RTL and testbench

Two-requester arbiter for the single data-memory port of the Mini-RISC-V SoC. Shares the BRAM data port between the core MEM stage (requester C) and a secondary bus master such as a UART loader or DMA engine (requester D). The core has fixed priority, with a bounded-starvation override for D. While D owns the port, the arbiter stalls the core pipeline through `mem_hold`. Read data returns through a latency-matched tag pipe so that each response reaches the requester that issued it.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter_rd_tag_pipe.sv | 35 +++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_pkg;

  // Which requester a memory access belongs to.
  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Read-return tag carried alongside an in-flight read.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam int RD_LAT_DEF   = 1;
  localparam int MAX_WAIT_DEF = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, secondary-master and memory-side signals around the arbiter.
interface dmem_arbiter_if;
  // core (C) side
  logic [3:0]  c_en;
  logic        c_wea;
  logic        c_rea;
  logic [31:0] c_addr;
  logic [31:0] c_din;
  logic [31:0] c_dout;
  logic        mem_hold;
  // secondary master (D) side
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  // memory side
  logic [3:0]  mem_en;
  logic        mem_wea;
  logic        mem_rea;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  // Arbiter's view.
  modport slave (
    input  c_en, c_wea, c_rea, c_addr, c_din,
    output c_dout, mem_hold,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_wea, mem_rea, mem_addr, mem_din,
    input  mem_dout
  );

  // Environment's view (requesters plus memory).
  modport master (
    output c_en, c_wea, c_rea, c_addr, c_din,
    input  c_dout, mem_hold,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_wea, mem_rea, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Latency-matched shift register of read tags with synchronous flush.
module rd_tag_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH = RD_LAT_DEF
) (
  input  logic clk,
  input  logic rst_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      tag_t stage_q;
      if (gi == 0) begin : g_head
        // First stage captures the tag of the read issued this cycle.
        always_ff @(posedge clk) begin
          if (rst_i) stage_q <= '0;
          else       stage_q <= tag_i;
        end
      end else begin : g_body
        // Later stages advance the tag one cycle closer to its data.
        always_ff @(posedge clk) begin
          if (rst_i) stage_q <= '0;
          else       stage_q <= g_stage[gi-1].stage_q;
        end
      end
    end
  endgenerate

  assign tag_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for the shared data-memory port with a bounded
// starvation override for the secondary master and tagged read returns.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input logic           clk,
  input logic           Rst,
  dmem_arbiter_if.slave bus
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   c_dout_q, c_dout_d;

  logic          c_req, d_win, c_win;
  logic [3:0]    mem_en_d;
  logic          mem_wea_d, mem_rea_d;
  logic [31:0]   mem_addr_d, mem_din_d;
  tag_t          tag_in, tag_out;
  logic          d_rvalid_d;

  // Pick the winner, steer it onto the memory port and advance the wait count.
  always_comb begin
    c_req      = |bus.c_en;
    d_win      = !Rst && bus.d_req && (!c_req || (wait_q == WAIT_MAX));
    c_win      = !Rst && c_req && !d_win;
    mem_en_d   = 4'h0;
    mem_wea_d  = 1'b0;
    mem_rea_d  = 1'b0;
    mem_addr_d = 32'h0;
    mem_din_d  = 32'h0;
    if (d_win) begin
      mem_en_d   = bus.d_be;
      mem_wea_d  = bus.d_we;
      mem_rea_d  = !bus.d_we;
      mem_addr_d = bus.d_addr;
      mem_din_d  = bus.d_wdata;
    end else if (c_win) begin
      mem_en_d   = bus.c_en;
      mem_wea_d  = bus.c_wea;
      mem_rea_d  = bus.c_rea;
      mem_addr_d = bus.c_addr;
      mem_din_d  = bus.c_din;
    end
    // D only waits while C holds the port; the count saturates at the limit.
    if (!bus.d_req || d_win)     wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
    else                         wait_d = wait_q;
    tag_in       = '0;
    tag_in.valid = mem_rea_d;
    tag_in.owner = d_win ? OWN_D : OWN_C;
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst_i (Rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Route returning read data to whichever requester issued the read.
  always_comb begin
    d_rvalid_d = !Rst && tag_out.valid && (tag_out.owner == OWN_D);
    c_dout_d   = c_dout_q;
    if (!Rst && tag_out.valid && (tag_out.owner == OWN_C)) c_dout_d = bus.mem_dout;
  end

  // Wait counter and the held core read-data value.
  always_ff @(posedge clk) begin
    if (Rst) begin
      wait_q   <= '0;
      c_dout_q <= 32'h0;
    end else begin
      wait_q   <= wait_d;
      c_dout_q <= c_dout_d;
    end
  end

  assign bus.mem_en   = mem_en_d;
  assign bus.mem_wea  = mem_wea_d;
  assign bus.mem_rea  = mem_rea_d;
  assign bus.mem_addr = mem_addr_d;
  assign bus.mem_din  = mem_din_d;
  assign bus.d_gnt    = d_win;
  assign bus.mem_hold = d_win && c_req;
  assign bus.c_dout   = c_dout_d;
  assign bus.d_rvalid = d_rvalid_d;
  assign bus.d_rdata  = d_rvalid_d ? bus.mem_dout : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (read latency 1, 2, 3) share one
// stimulus stream and are compared every cycle against a reference model.
module tb_dmem_arbiter;

  localparam int MAXW = 8;
  localparam int NI   = 3;
  localparam int NCYC = 4096;
  localparam logic [31:0] GARB = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic        rst;
  logic [3:0]  c_en;
  logic        c_wea, c_rea;
  logic [31:0] c_addr, c_din;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;

  // per-instance observations and memory read data
  logic [31:0] o_c_dout [NI];
  logic        o_hold   [NI];
  logic        o_gnt    [NI];
  logic        o_rvalid [NI];
  logic [31:0] o_rdata  [NI];
  logic [3:0]  o_en     [NI];
  logic        o_wea    [NI];
  logic        o_rea    [NI];
  logic [31:0] o_addr   [NI];
  logic [31:0] o_din    [NI];
  logic [31:0] m_dout   [NI];

  dmem_arbiter_if bus0 ();
  dmem_arbiter_if bus1 ();
  dmem_arbiter_if bus2 ();

  dmem_arbiter #(.RD_LAT(1), .MAX_WAIT(MAXW)) u_dut0 (.clk(clk), .Rst(rst), .bus(bus0));
  dmem_arbiter #(.RD_LAT(2), .MAX_WAIT(MAXW)) u_dut1 (.clk(clk), .Rst(rst), .bus(bus1));
  dmem_arbiter #(.RD_LAT(3), .MAX_WAIT(MAXW)) u_dut2 (.clk(clk), .Rst(rst), .bus(bus2));

  assign bus0.c_en = c_en;   assign bus0.c_wea = c_wea; assign bus0.c_rea = c_rea;
  assign bus0.c_addr = c_addr; assign bus0.c_din = c_din; assign bus0.d_req = d_req;
  assign bus0.d_we = d_we;   assign bus0.d_be = d_be;   assign bus0.d_addr = d_addr;
  assign bus0.d_wdata = d_wdata; assign bus0.mem_dout = m_dout[0];
  assign bus1.c_en = c_en;   assign bus1.c_wea = c_wea; assign bus1.c_rea = c_rea;
  assign bus1.c_addr = c_addr; assign bus1.c_din = c_din; assign bus1.d_req = d_req;
  assign bus1.d_we = d_we;   assign bus1.d_be = d_be;   assign bus1.d_addr = d_addr;
  assign bus1.d_wdata = d_wdata; assign bus1.mem_dout = m_dout[1];
  assign bus2.c_en = c_en;   assign bus2.c_wea = c_wea; assign bus2.c_rea = c_rea;
  assign bus2.c_addr = c_addr; assign bus2.c_din = c_din; assign bus2.d_req = d_req;
  assign bus2.d_we = d_we;   assign bus2.d_be = d_be;   assign bus2.d_addr = d_addr;
  assign bus2.d_wdata = d_wdata; assign bus2.mem_dout = m_dout[2];

  assign o_c_dout[0] = bus0.c_dout; assign o_hold[0] = bus0.mem_hold; assign o_gnt[0] = bus0.d_gnt;
  assign o_rvalid[0] = bus0.d_rvalid; assign o_rdata[0] = bus0.d_rdata; assign o_en[0] = bus0.mem_en;
  assign o_wea[0] = bus0.mem_wea; assign o_rea[0] = bus0.mem_rea; assign o_addr[0] = bus0.mem_addr;
  assign o_din[0] = bus0.mem_din;
  assign o_c_dout[1] = bus1.c_dout; assign o_hold[1] = bus1.mem_hold; assign o_gnt[1] = bus1.d_gnt;
  assign o_rvalid[1] = bus1.d_rvalid; assign o_rdata[1] = bus1.d_rdata; assign o_en[1] = bus1.mem_en;
  assign o_wea[1] = bus1.mem_wea; assign o_rea[1] = bus1.mem_rea; assign o_addr[1] = bus1.mem_addr;
  assign o_din[1] = bus1.mem_din;
  assign o_c_dout[2] = bus2.c_dout; assign o_hold[2] = bus2.mem_hold; assign o_gnt[2] = bus2.d_gnt;
  assign o_rvalid[2] = bus2.d_rvalid; assign o_rdata[2] = bus2.d_rdata; assign o_en[2] = bus2.mem_en;
  assign o_wea[2] = bus2.mem_wea; assign o_rea[2] = bus2.mem_rea; assign o_addr[2] = bus2.mem_addr;
  assign o_din[2] = bus2.mem_din;

  // Content of the memory: read data is a fixed scramble of the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory model per instance: instance k returns data k+1 cycles after a read.
  logic        hv [NI][3] = '{default: 1'b0};
  logic [31:0] ha [NI][3] = '{default: 32'h0};
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      for (int s = 2; s > 0; s--) begin
        hv[k][s] <= hv[k][s-1];
        ha[k][s] <= ha[k][s-1];
      end
      hv[k][0] <= o_rea[k];
      ha[k][0] <= o_addr[k];
    end
  end
  always_comb begin
    for (int k = 0; k < NI; k++) m_dout[k] = hv[k][k] ? mem_val(ha[k][k]) : GARB;
  end

  // reference model state
  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  int          waited = 0;
  int          last_rst = -1000;
  bit          iss_v [NCYC];
  bit          iss_d [NCYC];
  logic [31:0] iss_a [NCYC];
  logic [31:0] c_last [NI];
  bit          gnt_now;
  logic        obs_gnt0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0d got=%h want=%h", tag, k, t, obs, exp);
    end
  endtask

  // One clock cycle: predict from the arbitration rules, compare all instances.
  task automatic cycle();
    logic        cr, dw, cw;
    logic [3:0]  e_en;
    logic        e_wea, e_rea;
    logic [31:0] e_addr, e_din;
    int          s;
    bit          rv;
    @(negedge clk);
    cr = |c_en; dw = 1'b0; cw = 1'b0;
    e_en = 4'h0; e_wea = 1'b0; e_rea = 1'b0; e_addr = 32'h0; e_din = 32'h0;
    if (rst) begin
      waited   = 0;
      last_rst = t;
    end else begin
      if (d_req && (!cr || waited >= MAXW)) dw = 1'b1;
      else if (cr)                          cw = 1'b1;
      if (dw) begin
        e_en = d_be; e_wea = d_we; e_rea = !d_we; e_addr = d_addr; e_din = d_wdata;
      end else if (cw) begin
        e_en = c_en; e_wea = c_wea; e_rea = c_rea; e_addr = c_addr; e_din = c_din;
      end
      if (d_req && cw) waited = (waited < MAXW) ? waited + 1 : MAXW;
      else             waited = 0;
    end
    iss_v[t] = e_rea;
    iss_d[t] = dw;
    iss_a[t] = e_addr;
    gnt_now  = dw;
    obs_gnt0 = o_gnt[0];
    for (int k = 0; k < NI; k++) begin
      chk("d_gnt", k, o_gnt[k], dw);
      chk("mem_hold", k, o_hold[k], dw && cr);
      chk("mem_en", k, o_en[k], e_en);
      chk("mem_wea", k, o_wea[k], e_wea);
      chk("mem_rea", k, o_rea[k], e_rea);
      chk("mem_addr", k, o_addr[k], e_addr);
      chk("mem_din", k, o_din[k], e_din);
      s  = t - (k + 1);
      rv = !rst && (s >= 0) && (s > last_rst) && iss_v[s];
      if (rv && !iss_d[s]) c_last[k] = mem_val(iss_a[s]);
      chk("d_rvalid", k, o_rvalid[k], rv && iss_d[s]);
      chk("d_rdata", k, o_rdata[k], (rv && iss_d[s]) ? mem_val(iss_a[s]) : 32'h0);
      chk("c_dout", k, o_c_dout[k], c_last[k]);
      if (rst) c_last[k] = 32'h0;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_en = 4'h0; c_wea = 1'b0; c_rea = 1'b0; c_addr = 32'h0; c_din = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic c_read(input logic [31:0] a);
    c_en = 4'hF; c_rea = 1'b1; c_wea = 1'b0; c_addr = a; c_din = $urandom;
  endtask

  task automatic d_read(input logic [31:0] a);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = a; d_wdata = $urandom;
  endtask

  initial begin
    int  n;
    bit  d_pend;
    for (int k = 0; k < NI; k++) c_last[k] = 32'h0;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    // reset state
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // C-only read of 0x100, then its response
    c_read(32'h100);
    cycle();
    idle_inputs();
    cycle(); cycle(); cycle();

    // D-only write of 0xDEADBEEF to 0x40
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    cycle();
    idle_inputs();
    cycle(); cycle(); cycle();

    // continuous C stream, D read of 0x80 waits MAX_WAIT cycles
    d_read(32'h80);
    n = 0;
    c_read(32'h200);
    cycle();
    while (!obs_gnt0 && n < 20) begin
      n++;
      c_read(32'h200 + 32'(n * 4));
      cycle();
    end
    chk("starve_grant_cycle", 0, n, MAXW);
    d_req = 1'b0;
    c_read(32'h300);
    cycle();
    idle_inputs();
    cycle(); cycle(); cycle();

    // alternating C/D reads, one per cycle
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      if (i % 2 == 0) c_read({$urandom_range(0, 1023), 2'b00});
      else            d_read({$urandom_range(0, 1023), 2'b00});
      cycle();
    end
    idle_inputs();
    cycle(); cycle(); cycle(); cycle();

    // reset one cycle after a D read issues
    d_read(32'h1C0);
    cycle();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle(); cycle(); cycle(); cycle();

    // D drops its request at wait count 5 and reasserts
    d_read(32'hA0);
    for (int i = 0; i < 5; i++) begin
      c_read(32'h400 + 32'(i * 4));
      cycle();
    end
    d_req = 1'b0;
    c_read(32'h440);
    cycle();
    d_read(32'hA0);
    n = 0;
    c_read(32'h500);
    cycle();
    while (!obs_gnt0 && n < 20) begin
      n++;
      c_read(32'h500 + 32'(n * 4));
      cycle();
    end
    chk("restart_grant_cycle", 0, n, MAXW);
    idle_inputs();
    cycle(); cycle(); cycle();

    // random traffic with D honouring its hold-until-grant rule
    d_pend = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        c_en = 4'h0; c_rea = 1'b0; c_wea = 1'b0;
      end else begin
        c_en  = 4'($urandom_range(1, 15));
        c_rea = 1'($urandom_range(0, 1));
        c_wea = !c_rea;
      end
      c_addr = {$urandom_range(0, 4095), 2'b00};
      c_din  = $urandom;
      if (!d_pend) begin
        d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
        d_addr = {$urandom_range(0, 4095), 2'b00}; d_wdata = $urandom;
        d_pend = ($urandom_range(0, 2) == 0);
        d_req  = d_pend;
      end
      rst = ($urandom_range(0, 63) == 0);
      cycle();
      if (gnt_now || rst) begin
        d_pend = 1'b0;
        d_req  = 1'b0;
      end
    end
    rst = 1'b0;
    idle_inputs();
    cycle(); cycle(); cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
